// File: rtl/countdown_pkg.sv
// Shared types for the countdown sequencing controller.
package countdown_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } countdown_state_t;

endpackage

// File: rtl/countdown_core.sv
// N-bit count register: synchronous load, saturating decrement, resets to all ones.
module countdown_core #(
  parameter int N = 7
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         dec,
  output logic [N-1:0] value
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '1;
    end else if (load) begin
      value <= load_val;
    end else if (dec && (value != '0)) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/countdown_ctrl.sv
// Button-driven countdown sequencer: edge detect, tick prescaler, IDLE/RUN/PAUSE/DONE FSM.
// All actions land on the edge that samples the button rising; one action per cycle.
module countdown_ctrl
  import countdown_pkg::*;
#(
  parameter int N        = 7,
  parameter int TICK_DIV = 50_000_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start_btn,
  input  logic                pause_btn,
  input  logic                step_btn,
  input  logic [N-1:0]        load_value,
  output logic [N-1:0]        value,
  output logic                zero,
  output logic                busy,
  output logic                done_pulse,
  output logic [STATE_W-1:0]  state_o
);

  localparam int PSC_W = (TICK_DIV <= 1) ? 1 : $clog2(TICK_DIV);
  localparam logic [PSC_W-1:0] PSC_MAX = PSC_W'(TICK_DIV - 1);

  countdown_state_t state, state_nxt;
  logic [PSC_W-1:0] psc, psc_nxt;
  logic             start_prev, pause_prev, step_prev;
  logic             start_edge, pause_edge, step_edge;
  logic             load, dec, done_nxt;

  assign start_edge = start_btn & ~start_prev;
  assign pause_edge = pause_btn & ~pause_prev;
  assign step_edge  = step_btn  & ~step_prev;

  // Action decode; start outranks everything, then pause, step, tick.
  always_comb begin
    load      = 1'b0;
    dec       = 1'b0;
    done_nxt  = 1'b0;
    state_nxt = state;
    psc_nxt   = psc;
    if (start_edge) begin
      load    = 1'b1;
      psc_nxt = '0;
      if (load_value == '0) begin
        state_nxt = DONE;
        done_nxt  = 1'b1;
      end else begin
        state_nxt = RUN;
      end
    end else begin
      unique case (state)
        IDLE: begin
          dec = step_edge;
        end
        RUN: begin
          if (pause_edge) begin
            state_nxt = PAUSE;
          end else if (psc == PSC_MAX) begin
            psc_nxt = '0;
            dec     = 1'b1;
            if (value <= N'(1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end else begin
            psc_nxt = psc + 1'b1;
          end
        end
        PAUSE: begin
          if (pause_edge) begin
            state_nxt = RUN;
          end else if (step_edge) begin
            dec = 1'b1;
            if (value <= N'(1)) begin
              state_nxt = DONE;
              done_nxt  = 1'b1;
            end
          end
        end
        DONE: ;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      psc        <= '0;
      done_pulse <= 1'b0;
      start_prev <= 1'b0;
      pause_prev <= 1'b0;
      step_prev  <= 1'b0;
    end else begin
      state      <= state_nxt;
      psc        <= psc_nxt;
      done_pulse <= done_nxt;
      start_prev <= start_btn;
      pause_prev <= pause_btn;
      step_prev  <= step_btn;
    end
  end

  countdown_core #(.N(N)) u_core (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .load_val (load_value),
    .dec      (dec),
    .value    (value)
  );

  assign zero    = (value == '0);
  assign busy    = (state == RUN);
  assign state_o = state;

endmodule

// File: tb/tb_countdown_ctrl.sv
// Directed scoreboard bench for countdown_ctrl (N=7, TICK_DIV=4).
module tb_countdown_ctrl;

  localparam int N = 7;

  typedef struct packed {
    logic [N-1:0] v;
    logic [1:0]   st;
    logic         dp;
    logic         busy;
    logic         zero;
  } snap_t;

  logic         clk = 1'b0;
  logic         reset;
  logic         start_btn, pause_btn, step_btn;
  logic [N-1:0] load_value;
  logic [N-1:0] value;
  logic         zero, busy, done_pulse;
  logic [1:0]   state_o;

  snap_t exp_q[$];
  event  chk_ev;
  int    n_checks = 0;
  int    n_err    = 0;

  countdown_ctrl #(.N(N), .TICK_DIV(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .start_btn  (start_btn),
    .pause_btn  (pause_btn),
    .step_btn   (step_btn),
    .load_value (load_value),
    .value      (value),
    .zero       (zero),
    .busy       (busy),
    .done_pulse (done_pulse),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic push_exp(input logic [N-1:0] v, input logic [1:0] st, input logic dp);
    snap_t e;
    e.v    = v;
    e.st   = st;
    e.dp   = dp;
    e.busy = (st == 2'd1);
    e.zero = (v == '0);
    exp_q.push_back(e);
  endtask

  // Apply buttons for one edge and queue what the outputs must show after it.
  task automatic cyc(input logic s, input logic p, input logic t, input logic [N-1:0] lv,
                     input logic [N-1:0] ev, input logic [1:0] es, input logic ed);
    start_btn  = s;
    pause_btn  = p;
    step_btn   = t;
    load_value = lv;
    push_exp(ev, es, ed);
    @(posedge clk);
    #2;
  endtask

  task automatic hold(input int n, input logic [N-1:0] ev, input logic [1:0] es);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, '0, ev, es, 1'b0);
  endtask

  // Monitor: compares after every clock edge and on asynchronous checkpoints.
  initial begin
    snap_t e, g;
    forever begin
      @(posedge clk or chk_ev);
      #1;
      while (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = '{v: value, st: state_o, dp: done_pulse, busy: busy, zero: zero};
        n_checks++;
        if (g !== e) begin
          n_err++;
          $display("FAIL snapshot %0d: got value=%0d state=%0d done=%b busy=%b zero=%b, want value=%0d state=%0d done=%b busy=%b zero=%b",
                   n_checks, g.v, g.st, g.dp, g.busy, g.zero, e.v, e.st, e.dp, e.busy, e.zero);
        end
      end
    end
  end

  initial begin
    reset = 1'b1; start_btn = 1'b0; pause_btn = 1'b0; step_btn = 1'b0; load_value = '0;
    #2;
    push_exp(7'd127, 2'd0, 1'b0);
    -> chk_ev;
    @(posedge clk); #2;
    reset = 1'b0;
    hold(3, 7'd127, 2'd0);

    // Full run from 3 with a tick every 4 edges.
    cyc(1'b1, 1'b0, 1'b0, 7'd3, 7'd3, 2'd1, 1'b0);
    hold(3, 7'd3, 2'd1);
    hold(1, 7'd2, 2'd1);
    hold(3, 7'd2, 2'd1);
    hold(1, 7'd1, 2'd1);
    hold(3, 7'd1, 2'd1);
    cyc(1'b0, 1'b0, 1'b0, '0, 7'd0, 2'd3, 1'b1);
    hold(3, 7'd0, 2'd3);

    // Pause with the prescaler at 2, freeze, then resume two edges before the tick.
    cyc(1'b1, 1'b0, 1'b0, 7'd10, 7'd10, 2'd1, 1'b0);
    hold(2, 7'd10, 2'd1);
    cyc(1'b0, 1'b1, 1'b0, '0, 7'd10, 2'd2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, 1'b0, '0, 7'd10, 2'd2, 1'b0);
    hold(7, 7'd10, 2'd2);
    cyc(1'b0, 1'b1, 1'b0, '0, 7'd10, 2'd1, 1'b0);
    hold(1, 7'd10, 2'd1);
    hold(1, 7'd9, 2'd1);
    hold(3, 7'd9, 2'd1);
    hold(1, 7'd8, 2'd1);

    // Start and pause together in RUN: reload wins and the prescaler restarts.
    cyc(1'b1, 1'b1, 1'b0, 7'd20, 7'd20, 2'd1, 1'b0);
    hold(3, 7'd20, 2'd1);
    hold(1, 7'd19, 2'd1);

    // Zero load goes straight to DONE; pause/step are then ignored.
    cyc(1'b1, 1'b0, 1'b0, 7'd0, 7'd0, 2'd3, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, '0, 7'd0, 2'd3, 1'b0);
    hold(2, 7'd0, 2'd3);

    // Asynchronous reset between edges mid-RUN.
    cyc(1'b1, 1'b0, 1'b0, 7'd50, 7'd50, 2'd1, 1'b0);
    hold(2, 7'd50, 2'd1);
    reset = 1'b1;
    push_exp(7'd127, 2'd0, 1'b0);
    -> chk_ev;
    @(posedge clk); #2;
    reset = 1'b0;
    hold(1, 7'd127, 2'd0);

    // Held step in IDLE yields a single decrement.
    cyc(1'b0, 1'b0, 1'b1, '0, 7'd126, 2'd0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, '0, 7'd126, 2'd0, 1'b0);
    hold(1, 7'd126, 2'd0);

    // Step ignored in RUN; in PAUSE, stepping to 0 enters DONE.
    cyc(1'b1, 1'b0, 1'b0, 7'd2, 7'd2, 2'd1, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, '0, 7'd2, 2'd1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, '0, 7'd2, 2'd2, 1'b0);
    hold(1, 7'd2, 2'd2);
    cyc(1'b0, 1'b0, 1'b1, '0, 7'd1, 2'd2, 1'b0);
    hold(1, 7'd1, 2'd2);
    cyc(1'b0, 1'b0, 1'b1, '0, 7'd0, 2'd3, 1'b1);
    hold(2, 7'd0, 2'd3);

    @(posedge clk); #3;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected snapshots never compared, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/countdown_ctrl.md
# countdown_ctrl

Sequencing controller for the lab's N-bit countdown counter. It turns three already-debounced push-button inputs (start, pause, step) into load, decrement and hold commands. It runs the count down automatically at a programmable tick rate and flags completion. It sits between the board button conditioning logic and the 7-segment/LED display path, which consumes `value`.

## Interface
Parameters:
- `N`, default 7: counter width; reset value is 2^N-1.
- `TICK_DIV`, default 50_000_000: clk cycles per automatic decrement in RUN; legal range ≥1; 1 means decrement every cycle.

Ports:
- `clk`, in, 1: clock.
- `reset`, in, 1: asynchronous, active-high reset.
- `start_btn`, in, 1: debounced, synchronous level; a rising edge means start or restart.
- `pause_btn`, in, 1: debounced level; a rising edge toggles RUN/PAUSE.
- `step_btn`, in, 1: debounced level; a rising edge causes a manual single decrement (IDLE/PAUSE only).
- `load_value`, in, N: value loaded on start; sampled on the start-edge cycle.
- `value`, out, N: current count.
- `zero`, out, 1: combinational `value == 0`.
- `busy`, out, 1: high while state is RUN.
- `done_pulse`, out, 1: registered; one-cycle pulse on entry to DONE.
- `state_o`, out, 2: current state encoding.

## Operation
- Edge detection: each button has a `*_prev` flop, reset to 0. An edge means the input is 1 and its `*_prev` is 0 at a clk rising edge. A held button produces exactly one edge.
- States, with `state_o` encoding: IDLE=0, RUN=1, PAUSE=2, DONE=3.
- Priority within a cycle: start > pause > step > tick. Only one action is taken per cycle.
- IDLE:
  - start edge → load `load_value` and clear the prescaler. Go to DONE (with done_pulse) if `load_value`==0, else go to RUN.
  - step edge → decrement if `value`>0, saturating at 0. State unchanged.
- RUN:
  - The prescaler counts 0..TICK_DIV-1. The cycle it equals TICK_DIV-1 is a tick: the prescaler wraps to 0 and `value` decrements.
  - A tick taking `value` from 1 to 0 → DONE, with done_pulse.
  - pause edge → PAUSE. The prescaler holds, and no decrement happens even if that cycle is a tick.
  - start edge → reload, prescaler cleared, with the same 0-check as in IDLE.
  - step edge is ignored.
- PAUSE:
  - The prescaler and `value` hold.
  - pause edge → RUN, and the prescaler resumes from its held value.
  - start edge → reload as above.
  - step edge → decrement; reaching 0 → DONE with done_pulse.
- DONE:
  - `value` holds 0.
  - start edge → reload as above.
  - pause and step edges are ignored.
- Arithmetic:
  - The decrement is unsigned N-bit and never wraps below 0.
  - The prescaler width is max(1, $clog2(TICK_DIV)).

## Timing
- Reset (asynchronous assert):
  - `value`=2^N-1, state IDLE, prescaler 0, `done_pulse`=0, all `*_prev`=0.
  - Resulting outputs: `busy`=0, `zero`=0, `state_o`=0.
  - Reset mid-RUN or mid-PAUSE takes effect immediately, without waiting for a clock edge.
- Button response: all updates take effect on the same clk edge that samples the rising edge. `value`/`state_o` are new one cycle after the button first reads high.
- RUN cadence: after a start at edge k, the first decrement occurs at edge k+TICK_DIV, and every TICK_DIV edges after that.
- done_pulse is high for exactly the one cycle in which `state_o` first reads DONE.
- `zero` and `busy` are combinational from registered state; they add no latency.

## Structure
- Package `countdown_pkg` contains:
  - `typedef enum logic [1:0] countdown_state_t` with {IDLE, RUN, PAUSE, DONE}.
  - A state-width localparam.
- Sub-module `countdown_core #(N)` is the value register:
  - Inputs: `load`, `load_val`, `dec`.
  - Reset value is all ones; decrement saturates at 0.
  - Output: `value`.
- countdown_ctrl holds the FSM, prescaler, edge detectors and done_pulse.

## Test plan
Run with N=7 and TICK_DIV=4.
- **Reset:** assert reset → `value`=127, `state_o`=0, `busy`=0, `zero`=0, `done_pulse`=0. Deassert → outputs unchanged while all buttons stay low.
- **Full run:** `load_value`=3, start pulse at edge k → `value`=3 and RUN at k. Then `value`=2 at k+4, 1 at k+8, 0 at k+12. DONE and done_pulse=1 for only the k+12 cycle; `value` stays 0.
- **Pause/resume:** during RUN with the prescaler at 2, pause edge → PAUSE and `value` frozen for 10 cycles. Second pause edge → the next decrement comes exactly 2 cycles later.
- **Zero load and priority:** start with `load_value`=0 → DONE plus done_pulse on the same edge. Start and pause rising together in RUN → reload, stay RUN, prescaler 0.
- **Manual step:** in IDLE from 127, hold step_btn high for 5 cycles → exactly one decrement, to 126. In PAUSE at `value`=1, step → 0, DONE, done_pulse.
- **Async reset mid-RUN:** assert reset between clk edges → `value`=127 and IDLE immediately, with no clk edge needed.
